axi4lite_cfg_master: RTL and testbench
======================================

// Module: axi4lite_cfg_master
// PURPOSE
//  Initiator end of the cfg bus <-> AXI4-Lite bridge. Accepts single register read/write
//  commands on a valid/ready cmd port and issues them as AXI4-Lite master transactions to an
//  AXI4-Lite config slave (e.g. a peer fabric block's register file).
//  Returns read data and response code on a valid/ready rsp port. One transaction outstanding.
// PARAMETERS
//  CFG_AWIDTH      5             cfg register index width (word index)
//  CFG_DWIDTH      32            cfg/AXI data width; AXI4-Lite, fixed 32
//  AXI_ADDR_WIDTH  32            AXI byte address width
//  BASE_ADDR       32'h43C00000  byte address of cfg register 0 on the target slave
// PORTS
//  clk             in   1              clock
//  rst             in   1              synchronous reset, active-high
//  cmd_addr        in   CFG_AWIDTH     register index
//  cmd_data        in   CFG_DWIDTH     write data (ignored for reads)
//  cmd_wr          in   1              1=write, 0=read
//  cmd_valid       in   1              command valid
//  cmd_ready       out  1              command accepted when valid&ready
//  rsp_data        out  CFG_DWIDTH     read data; 0 for writes
//  rsp_resp        out  2              AXI BRESP/RRESP of the transaction
//  rsp_valid       out  1              response valid
//  rsp_ready       in   1              response consumed when valid&ready
//  axi_awaddr      out  AXI_ADDR_WIDTH write address
//  axi_awprot      out  3              tied 3'b000
//  axi_awvalid     out  1              / axi_awready in 1: AW handshake
//  axi_wdata       out  32             write data
//  axi_wstrb       out  4              tied 4'hF
//  axi_wvalid      out  1              / axi_wready in 1: W handshake
//  axi_bresp       in   2              write response
//  axi_bvalid      in   1              / axi_bready out 1: B handshake
//  axi_araddr      out  AXI_ADDR_WIDTH read address
//  axi_arprot      out  3              tied 3'b000
//  axi_arvalid     out  1              / axi_arready in 1: AR handshake
//  axi_rdata       in   32             read data
//  axi_rresp       in   2              read response
//  axi_rvalid      in   1              / axi_rready out 1: R handshake
// BEHAVIOUR
//  - Reset: state IDLE; cmd_ready=1; rsp_valid, all AXI valids, bready, rready =0; rsp_data, rsp_resp, addr/data regs =0.
//  - Address: BASE_ADDR + {cmd_addr,2'b00}, zero-extended, modulo 2^AXI_ADDR_WIDTH.
//  - FSM IDLE->WR_AW_W->WR_B->RSP->IDLE (write) | IDLE->RD_AR->RD_R->RSP->IDLE (read).
//  - IDLE: cmd_ready=1; on cmd_valid, register addr/data/cmd_wr; next cycle valids assert (1-cycle latency).
//  - WR_AW_W: awvalid and wvalid asserted together, each dropped the cycle after its own handshake;
//    either order or simultaneous legal; leave when both done. WR_B: bready=1; on bvalid capture bresp.
//  - RD_AR: arvalid until arready. RD_R: rready=1; on rvalid capture rdata, rresp.
//  - RSP: rsp_valid=1 with stable data until rsp_ready; then IDLE (cmd_ready=1 next cycle).
//    Best case: write 4 cycles, read 4 cycles cmd accept -> rsp_valid with zero-wait slave.
//  - AXI rules: valid never withdrawn before handshake; addr/data stable while valid; no combinational
//    path from any AXI ready/valid input to any AXI output.
//  - bvalid/rvalid outside WR_B/RD_R ignored (ready low). cmd_ready=0 in every non-IDLE state.
//  - rsp_resp reported verbatim (SLVERR/DECERR not retried); rsp_data=0 on writes.
//  - rst mid-transaction: IDLE next cycle, all valids drop; in-flight command discarded, no response.
// TESTING
//  - write idx 4, 0xDEADBEEF, awready delayed 3 cycles, wready immediate -> awaddr 0x43C00010, wvalid
//    drops after 1st cycle, awvalid held 4 cycles, bresp 0 -> rsp_valid, rsp_resp 0, rsp_data 0.
//  - read idx 2, slave rdata 0x00001234 rresp 0 -> araddr 0x43C00008, rsp_data 0x1234, rsp_resp 0.
//  - read idx 31, rresp 2'b10 -> araddr 0x43C0007C, rsp_resp 2'b10, rdata passed through.
//  - rsp_ready low 5 cycles -> rsp_valid/rsp_data stable, cmd_ready 0, new cmd_valid not accepted.
//  - rst asserted while awvalid pending -> next cycle all valids 0, cmd_ready 1, no rsp_valid.
//  - 3 back-to-back commands (W,R,W) with cmd_valid held -> each accepted only in IDLE, responses in order.

Source files
------------

// File: rtl/axi4lite_cfg_master.sv
// Bridges single cfg-bus register commands onto an AXI4-Lite master port, one transaction at a time.
// Every cmd, rsp and AXI output is driven straight from a flop.
module axi4lite_cfg_master #(
  parameter int                        CFG_AWIDTH     = 5,
  parameter int                        CFG_DWIDTH     = 32,
  parameter int                        AXI_ADDR_WIDTH = 32,
  parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR      = 32'h43C00000
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [CFG_AWIDTH-1:0]     i_cmd_addr,
  input  logic [CFG_DWIDTH-1:0]     i_cmd_data,
  input  logic                      i_cmd_wr,
  input  logic                      i_cmd_valid,
  output logic                      o_cmd_ready,
  output logic [CFG_DWIDTH-1:0]     o_rsp_data,
  output logic [1:0]                o_rsp_resp,
  output logic                      o_rsp_valid,
  input  logic                      i_rsp_ready,
  output logic [AXI_ADDR_WIDTH-1:0] o_axi_awaddr,
  output logic [2:0]                o_axi_awprot,
  output logic                      o_axi_awvalid,
  input  logic                      i_axi_awready,
  output logic [CFG_DWIDTH-1:0]     o_axi_wdata,
  output logic [3:0]                o_axi_wstrb,
  output logic                      o_axi_wvalid,
  input  logic                      i_axi_wready,
  input  logic [1:0]                i_axi_bresp,
  input  logic                      i_axi_bvalid,
  output logic                      o_axi_bready,
  output logic [AXI_ADDR_WIDTH-1:0] o_axi_araddr,
  output logic [2:0]                o_axi_arprot,
  output logic                      o_axi_arvalid,
  input  logic                      i_axi_arready,
  input  logic [CFG_DWIDTH-1:0]     i_axi_rdata,
  input  logic [1:0]                i_axi_rresp,
  input  logic                      i_axi_rvalid,
  output logic                      o_axi_rready
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_AW_W = 3'd1,
    S_WR_B    = 3'd2,
    S_RD_AR   = 3'd3,
    S_RD_R    = 3'd4,
    S_RSP     = 3'd5
  } state_t;

  state_t                    r_state;
  logic                      r_cmd_ready;
  logic                      r_awvalid;
  logic                      r_wvalid;
  logic                      r_bready;
  logic                      r_arvalid;
  logic                      r_rready;
  logic [AXI_ADDR_WIDTH-1:0] r_addr;
  logic [CFG_DWIDTH-1:0]     r_wdata;
  logic [CFG_DWIDTH-1:0]     r_rsp_data;
  logic [1:0]                r_rsp_resp;
  logic                      r_rsp_valid;

  state_t                    w_state_nxt;
  logic                      w_cmd_ready_nxt;
  logic                      w_awvalid_nxt;
  logic                      w_wvalid_nxt;
  logic                      w_bready_nxt;
  logic                      w_arvalid_nxt;
  logic                      w_rready_nxt;
  logic [AXI_ADDR_WIDTH-1:0] w_addr_nxt;
  logic [CFG_DWIDTH-1:0]     w_wdata_nxt;
  logic [CFG_DWIDTH-1:0]     w_rsp_data_nxt;
  logic [1:0]                w_rsp_resp_nxt;
  logic                      w_rsp_valid_nxt;
  logic [AXI_ADDR_WIDTH-1:0] w_offset;
  logic                      w_aw_ok;
  logic                      w_w_ok;

  // Word index to byte offset; the add below wraps modulo the AXI address width.
  assign w_offset = AXI_ADDR_WIDTH'({i_cmd_addr, 2'b00});
  // A channel is finished once its valid is low or is being accepted on this edge.
  assign w_aw_ok  = !r_awvalid || i_axi_awready;
  assign w_w_ok   = !r_wvalid  || i_axi_wready;

  always_comb begin
    w_state_nxt     = r_state;
    w_cmd_ready_nxt = r_cmd_ready;
    w_awvalid_nxt   = r_awvalid;
    w_wvalid_nxt    = r_wvalid;
    w_bready_nxt    = r_bready;
    w_arvalid_nxt   = r_arvalid;
    w_rready_nxt    = r_rready;
    w_addr_nxt      = r_addr;
    w_wdata_nxt     = r_wdata;
    w_rsp_data_nxt  = r_rsp_data;
    w_rsp_resp_nxt  = r_rsp_resp;
    w_rsp_valid_nxt = r_rsp_valid;
    case (r_state)
      S_IDLE: begin
        if (i_cmd_valid) begin
          w_cmd_ready_nxt = 1'b0;
          w_addr_nxt      = BASE_ADDR + w_offset;
          if (i_cmd_wr) begin
            w_wdata_nxt   = i_cmd_data;
            w_awvalid_nxt = 1'b1;
            w_wvalid_nxt  = 1'b1;
            w_state_nxt   = S_WR_AW_W;
          end else begin
            w_wdata_nxt   = {CFG_DWIDTH{1'b0}};
            w_arvalid_nxt = 1'b1;
            w_state_nxt   = S_RD_AR;
          end
        end else begin
          w_cmd_ready_nxt = 1'b1;
        end
      end
      S_WR_AW_W: begin
        if (r_awvalid && i_axi_awready) begin
          w_awvalid_nxt = 1'b0;
        end else begin
          w_awvalid_nxt = r_awvalid;
        end
        if (r_wvalid && i_axi_wready) begin
          w_wvalid_nxt = 1'b0;
        end else begin
          w_wvalid_nxt = r_wvalid;
        end
        if (w_aw_ok && w_w_ok) begin
          w_bready_nxt = 1'b1;
          w_state_nxt  = S_WR_B;
        end else begin
          w_state_nxt  = S_WR_AW_W;
        end
      end
      S_WR_B: begin
        if (i_axi_bvalid) begin
          w_bready_nxt    = 1'b0;
          w_rsp_data_nxt  = {CFG_DWIDTH{1'b0}};
          w_rsp_resp_nxt  = i_axi_bresp;
          w_rsp_valid_nxt = 1'b1;
          w_state_nxt     = S_RSP;
        end else begin
          w_state_nxt = S_WR_B;
        end
      end
      S_RD_AR: begin
        if (i_axi_arready) begin
          w_arvalid_nxt = 1'b0;
          w_rready_nxt  = 1'b1;
          w_state_nxt   = S_RD_R;
        end else begin
          w_state_nxt = S_RD_AR;
        end
      end
      S_RD_R: begin
        if (i_axi_rvalid) begin
          w_rready_nxt    = 1'b0;
          w_rsp_data_nxt  = i_axi_rdata;
          w_rsp_resp_nxt  = i_axi_rresp;
          w_rsp_valid_nxt = 1'b1;
          w_state_nxt     = S_RSP;
        end else begin
          w_state_nxt = S_RD_R;
        end
      end
      S_RSP: begin
        if (i_rsp_ready) begin
          w_rsp_valid_nxt = 1'b0;
          w_cmd_ready_nxt = 1'b1;
          w_state_nxt     = S_IDLE;
        end else begin
          w_state_nxt = S_RSP;
        end
      end
      default: begin
        w_state_nxt     = S_IDLE;
        w_cmd_ready_nxt = 1'b1;
        w_awvalid_nxt   = 1'b0;
        w_wvalid_nxt    = 1'b0;
        w_bready_nxt    = 1'b0;
        w_arvalid_nxt   = 1'b0;
        w_rready_nxt    = 1'b0;
        w_rsp_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_cmd_ready <= 1'b1;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_addr      <= {AXI_ADDR_WIDTH{1'b0}};
      r_wdata     <= {CFG_DWIDTH{1'b0}};
      r_rsp_data  <= {CFG_DWIDTH{1'b0}};
      r_rsp_resp  <= 2'b00;
      r_rsp_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cmd_ready <= w_cmd_ready_nxt;
      r_awvalid   <= w_awvalid_nxt;
      r_wvalid    <= w_wvalid_nxt;
      r_bready    <= w_bready_nxt;
      r_arvalid   <= w_arvalid_nxt;
      r_rready    <= w_rready_nxt;
      r_addr      <= w_addr_nxt;
      r_wdata     <= w_wdata_nxt;
      r_rsp_data  <= w_rsp_data_nxt;
      r_rsp_resp  <= w_rsp_resp_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
    end
  end

  assign o_cmd_ready   = r_cmd_ready;
  assign o_rsp_data    = r_rsp_data;
  assign o_rsp_resp    = r_rsp_resp;
  assign o_rsp_valid   = r_rsp_valid;
  assign o_axi_awaddr  = r_addr;
  assign o_axi_awprot  = 3'b000;
  assign o_axi_awvalid = r_awvalid;
  assign o_axi_wdata   = r_wdata;
  assign o_axi_wstrb   = 4'hF;
  assign o_axi_wvalid  = r_wvalid;
  assign o_axi_bready  = r_bready;
  assign o_axi_araddr  = r_addr;
  assign o_axi_arprot  = 3'b000;
  assign o_axi_arvalid = r_arvalid;
  assign o_axi_rready  = r_rready;

endmodule

// File: tb/tb_axi4lite_cfg_master.sv
// Directed bench for axi4lite_cfg_master: a table of cfg commands played against a scripted
// AXI4-Lite slave, plus reset-abort and held-cmd_valid sequences.
module tb_axi4lite_cfg_master;

  logic        clk;
  logic        rst;
  logic [4:0]  cmd_addr;
  logic [31:0] cmd_data;
  logic        cmd_wr;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_resp;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  int checks   = 0;
  int failures = 0;

  axi4lite_cfg_master dut (
    .i_clk(clk), .i_rst(rst),
    .i_cmd_addr(cmd_addr), .i_cmd_data(cmd_data), .i_cmd_wr(cmd_wr),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
    .o_rsp_data(rsp_data), .o_rsp_resp(rsp_resp), .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_axi_awaddr(awaddr), .o_axi_awprot(awprot), .o_axi_awvalid(awvalid), .i_axi_awready(awready),
    .o_axi_wdata(wdata), .o_axi_wstrb(wstrb), .o_axi_wvalid(wvalid), .i_axi_wready(wready),
    .i_axi_bresp(bresp), .i_axi_bvalid(bvalid), .o_axi_bready(bready),
    .o_axi_araddr(araddr), .o_axi_arprot(arprot), .o_axi_arvalid(arvalid), .i_axi_arready(arready),
    .i_axi_rdata(rdata), .i_axi_rresp(rresp), .i_axi_rvalid(rvalid), .o_axi_rready(rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [4:0]  idx;
    logic [31:0] data;
    int          aw_dly;    // awready (or arready) delay in cycles
    int          w_dly;     // wready delay in cycles
    logic [1:0]  resp;      // slave BRESP/RRESP
    logic [31:0] rdata;     // slave RDATA
    int          stall;     // cycles rsp_ready held low
    logic        keep;      // leave cmd_valid high after acceptance
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Entered and left at a negedge with the DUT idle.
  task automatic run_vec(input vec_t v);
    int   c;
    logic a_done;
    logic w_done;
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_wr = v.wr; cmd_addr = v.idx; cmd_data = v.data;
    @(negedge clk);
    if (!v.keep) cmd_valid = 1'b0;
    chk("cmd_ready_busy", cmd_ready, 0);
    if (v.wr) begin
      chk("awaddr", awaddr, v.exp_addr);
      chk("wdata", wdata, v.data);
      chk("arvalid_on_write", arvalid, 0);
      a_done = 1'b0; w_done = 1'b0; c = 0;
      rvalid = 1'b1; rdata = 32'hBAD0BAD0; rresp = 2'b11;
      while (!(a_done && w_done) && c < 40) begin
        if (c > 0) @(negedge clk);
        chk("awvalid_hold", awvalid, !a_done);
        chk("wvalid_hold", wvalid, !w_done);
        awready = !a_done && (c >= v.aw_dly);
        wready  = !w_done && (c >= v.w_dly);
        if (awvalid && awready) a_done = 1'b1;
        if (wvalid && wready) w_done = 1'b1;
        c++;
      end
      @(negedge clk);
      awready = 1'b0; wready = 1'b0; rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00;
      c = 0;
      while (!bready && c < 20) begin @(negedge clk); c++; end
      chk("bready", bready, 1);
      chk("aw_w_dropped", {awvalid, wvalid}, 0);
      bvalid = 1'b1; bresp = v.resp;
      @(negedge clk);
      bvalid = 1'b0; bresp = 2'b00;
    end else begin
      chk("araddr", araddr, v.exp_addr);
      chk("awvalid_on_read", awvalid, 0);
      chk("wvalid_on_read", wvalid, 0);
      a_done = 1'b0; c = 0;
      bvalid = 1'b1; bresp = 2'b11;
      while (!a_done && c < 40) begin
        if (c > 0) @(negedge clk);
        chk("arvalid_hold", arvalid, 1);
        arready = (c >= v.aw_dly);
        if (arvalid && arready) a_done = 1'b1;
        c++;
      end
      @(negedge clk);
      arready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
      c = 0;
      while (!rready && c < 20) begin @(negedge clk); c++; end
      chk("rready", rready, 1);
      chk("arvalid_dropped", arvalid, 0);
      rvalid = 1'b1; rdata = v.rdata; rresp = v.resp;
      @(negedge clk);
      rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00;
    end
    c = 0;
    while (!rsp_valid && c < 20) begin @(negedge clk); c++; end
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_data", rsp_data, v.exp_data);
    chk("rsp_resp", rsp_resp, v.resp);
    chk("cmd_ready_rsp", cmd_ready, 0);
    for (int i = 0; i < v.stall; i++) begin
      if (!v.keep) begin
        cmd_valid = 1'b1; cmd_wr = ~v.wr; cmd_addr = 5'd7; cmd_data = 32'h77777777;
      end
      @(negedge clk);
      chk("stall_rsp_valid", rsp_valid, 1);
      chk("stall_rsp_data", rsp_data, v.exp_data);
      chk("stall_rsp_resp", rsp_resp, v.resp);
      chk("stall_cmd_ready", cmd_ready, 0);
      chk("stall_no_axi", {awvalid, wvalid, arvalid}, 0);
    end
    rsp_ready = 1'b1;
    if (!v.keep) cmd_valid = 1'b0;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", rsp_valid, 0);
    chk("cmd_ready_back", cmd_ready, 1);
    chk("no_new_axi", {awvalid, wvalid, arvalid}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //              wr    idx    data          aw dly w dly resp   rdata         stall keep  exp_addr      exp_data
    vecs[0] = '{1'b1, 5'd4,  32'hDEADBEEF, 3, 0, 2'b00, 32'h00000000, 0, 1'b0, 32'h43C00010, 32'h00000000};
    vecs[1] = '{1'b0, 5'd2,  32'h00000000, 0, 0, 2'b00, 32'h00001234, 5, 1'b0, 32'h43C00008, 32'h00001234};
    vecs[2] = '{1'b0, 5'd31, 32'h00000000, 2, 0, 2'b10, 32'hA5A50001, 0, 1'b0, 32'h43C0007C, 32'hA5A50001};
    vecs[3] = '{1'b1, 5'd0,  32'h00000001, 0, 2, 2'b11, 32'h00000000, 0, 1'b0, 32'h43C00000, 32'h00000000};
    vecs[4] = '{1'b1, 5'd31, 32'hFFFFFFFF, 1, 1, 2'b01, 32'h00000000, 0, 1'b0, 32'h43C0007C, 32'h00000000};
    vecs[5] = '{1'b0, 5'd0,  32'h00000000, 1, 0, 2'b11, 32'hFFFFFFFF, 0, 1'b0, 32'h43C00000, 32'hFFFFFFFF};
    vecs[6] = '{1'b1, 5'd1,  32'h11111111, 0, 0, 2'b00, 32'h00000000, 0, 1'b1, 32'h43C00004, 32'h00000000};
    vecs[7] = '{1'b0, 5'd3,  32'h00000000, 0, 0, 2'b00, 32'hCAFE0003, 0, 1'b1, 32'h43C0000C, 32'hCAFE0003};
    vecs[8] = '{1'b1, 5'd5,  32'h00005555, 2, 0, 2'b10, 32'h00000000, 0, 1'b0, 32'h43C00014, 32'h00000000};

    rst = 1'b1; cmd_addr = 5'd0; cmd_data = 32'h0; cmd_wr = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
    awready = 1'b0; wready = 1'b0; bresp = 2'b00; bvalid = 1'b0;
    arready = 1'b0; rdata = 32'h0; rresp = 2'b00; rvalid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_axi_valids", {awvalid, wvalid, arvalid, bready, rready}, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_resp", rsp_resp, 0);
    chk("rst_awaddr", awaddr, 0);
    chk("rst_wdata", wdata, 0);
    chk("tied_prot_strb", {awprot, arprot, wstrb}, 32'h0000000F);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Reset while awvalid is pending: command dropped, no response.
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 5'd9; cmd_data = 32'h99999999;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("abort_awvalid", awvalid, 1);
    @(negedge clk);
    chk("abort_awvalid_held", awvalid, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_valids", {awvalid, wvalid, arvalid, bready, rready}, 0);
    chk("abort_cmd_ready", cmd_ready, 1);
    chk("abort_rsp_valid", rsp_valid, 0);
    repeat (3) @(negedge clk);
    chk("abort_quiet", {rsp_valid, awvalid, wvalid, arvalid}, 0);

    // Back-to-back W, R, W with cmd_valid held between commands.
    for (int i = 6; i < 9; i++) run_vec(vecs[i]);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("final_idle", {cmd_ready, rsp_valid, awvalid, arvalid}, 32'h8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
